// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package loader_pkg;

    localparam int unsigned CNT_W          = 16;
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam bit          MSB_FIRST      = 1'b1;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_WRITE,
        ST_FIN,
        ST_FAIL
    } state_e;

endpackage

// File: rtl/word_packer.sv
// Assembles four stream bytes into one instruction word, first byte in the MSBs.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [1:0]  idx_o,
    output logic        full_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        full_q, full_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        full_d = full_q;
        if (clear) begin
            idx_d  = '0;
            full_d = 1'b0;
        end else if (load) begin
            if (MSB_FIRST) word_d = {word_q[23:0], byte_i};
            else           word_d = {byte_i, word_q[31:8]};
            idx_d  = idx_q + 2'd1;
            full_d = (idx_q == 2'(BYTES_PER_WORD - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            full_q <= full_d;
        end
    end

    assign word_o = word_q;
    assign idx_o  = idx_q;
    assign full_o = full_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory, holding the core in reset meanwhile.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        RX_VALID,
    input  logic [7:0]  RX_DATA,
    output logic        RX_READY,
    output logic [31:0] W_ADDR,
    output logic [31:0] W_Ins,
    output logic        WE,
    output logic        CPU_RST,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    cnt_t        rem_q, rem_d;
    logic [7:0]  cnt_hi_q, cnt_hi_d;

    logic        pk_clear, pk_load, pk_full;
    logic [1:0]  pk_idx;
    logic [31:0] pk_word;
    cnt_t        hdr_count;
    logic        rx_ready;
    logic        xfer;

    word_packer u_packer (
        .clk    (CLK),
        .rst_n  (RST),
        .clear  (pk_clear),
        .load   (pk_load),
        .byte_i (RX_DATA),
        .word_o (pk_word),
        .idx_o  (pk_idx),
        .full_o (pk_full)
    );

    // Handshake readiness is a pure state decode, so RX_VALID never reaches an output.
    assign rx_ready  = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) || (state_q == ST_DATA);
    assign xfer      = RX_VALID && rx_ready;
    assign hdr_count = {cnt_hi_q, RX_DATA};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        cnt_hi_d = cnt_hi_q;
        pk_clear = 1'b0;
        pk_load  = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN, ST_FAIL: begin
                if (START) begin
                    state_d = ST_HDR_HI;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_HDR_HI: begin
                if (xfer) begin
                    cnt_hi_d = RX_DATA;
                    state_d  = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (xfer) begin
                    if (32'(hdr_count) > DEPTH) begin
                        state_d = ST_FAIL;
                    end else if (hdr_count == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        rem_d    = hdr_count;
                        pk_clear = 1'b1;
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    pk_load = 1'b1;
                    if (pk_idx == 2'(BYTES_PER_WORD - 1)) state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + 32'd4;
                rem_d   = rem_q - cnt_t'(1);
                state_d = (rem_q == cnt_t'(1)) ? ST_FIN : ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            addr_q   <= BASE_ADDR;
            rem_q    <= '0;
            cnt_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            cnt_hi_q <= cnt_hi_d;
        end
    end

    assign RX_READY = rx_ready;
    assign W_ADDR   = addr_q;
    assign W_Ins    = pk_word;
    assign WE       = (state_q == ST_WRITE) && pk_full;
    assign CPU_RST  = (state_q != ST_FIN);
    assign BUSY     = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_WRITE);
    assign DONE     = (state_q == ST_FIN);
    assign ERR      = (state_q == ST_FAIL);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte images and checks write strobes and status outputs.
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        RX_VALID = 1'b0;
    logic [7:0]  RX_DATA = '0;
    logic        RX_READY;
    logic [31:0] W_ADDR;
    logic [31:0] W_Ins;
    logic        WE;
    logic        CPU_RST;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic        wr[$];

    int          end_edge;
    int          consumed;
    logic        cpu_rst_e0;
    logic        done_e0;

    imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .RX_VALID (RX_VALID),
        .RX_DATA  (RX_DATA),
        .RX_READY (RX_READY),
        .W_ADDR   (W_ADDR),
        .W_Ins    (W_Ins),
        .WE       (WE),
        .CPU_RST  (CPU_RST),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WE === 1'b1) begin
            wa.push_back(W_ADDR);
            wd.push_back(W_Ins);
            wr.push_back(RX_READY);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_rst"},  32'(CPU_RST),  32'd1);
        check({tag, "_we"},       32'(WE),       32'd0);
        check({tag, "_w_addr"},   W_ADDR,        32'h0);
        check({tag, "_w_ins"},    W_Ins,         32'h0);
        check({tag, "_rx_ready"}, 32'(RX_READY), 32'd0);
        check({tag, "_busy"},     32'(BUSY),     32'd0);
        check({tag, "_done"},     32'(DONE),     32'd0);
        check({tag, "_err"},      32'(ERR),      32'd0);
    endtask

    // Edge k=0 is the START edge; end_edge is the edge after which DONE or ERR is seen.
    task automatic run_load(input bq_t img, input bit toggle, input int stop_at);
        int idx;
        logic rdy;
        logic v;
        idx = 0;
        end_edge = -1;
        wa.delete(); wd.delete(); wr.delete();
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            START = (k == 0);
            if (idx < img.size() && (!toggle || (k % 2 == 0))) begin
                RX_VALID = 1'b1;
                RX_DATA  = img[idx];
            end else begin
                RX_VALID = 1'b0;
            end
            rdy = RX_READY;
            v   = RX_VALID;
            @(posedge CLK);
            if (v && rdy) idx++;
            #1;
            if (k == 0) begin
                cpu_rst_e0 = CPU_RST;
                done_e0    = DONE;
            end
            if (stop_at >= 0 && idx == stop_at) begin
                end_edge = k;
                break;
            end
            if (k > 0 && (DONE || ERR)) begin
                end_edge = k;
                break;
            end
        end
        consumed = idx;
        @(negedge CLK);
        START    = 1'b0;
        RX_VALID = 1'b0;
        if (end_edge < 0) check("load_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        bq_t img;

        #12;
        check_reset_values("rst");
        @(negedge CLK);
        RST = 1'b1;

        // Two-word image, minimum load time 2 + 5N = 12
        img = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        run_load(img, 1'b0, -1);
        check("n2_end_edge", 32'(end_edge), 32'd12);
        check("n2_we_count", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("n2_addr0", wa[0], 32'h0);
            check("n2_data0", wd[0], 32'h2408_0005);
            check("n2_addr1", wa[1], 32'h4);
            check("n2_data1", wd[1], 32'h0000_000C);
            check("n2_rdy_in_write", 32'(wr[0]), 32'd0);
        end
        check("n2_done",    32'(DONE),    32'd1);
        check("n2_cpu_rst", 32'(CPU_RST), 32'd0);
        check("n2_busy",    32'(BUSY),    32'd0);
        check("n2_err",     32'(ERR),     32'd0);

        // Empty image
        img = '{8'h00, 8'h00};
        run_load(img, 1'b0, -1);
        check("n0_end_edge", 32'(end_edge), 32'd2);
        check("n0_we_count", 32'(wa.size()), 32'd0);
        check("n0_done",     32'(DONE),      32'd1);
        check("n0_cpu_rst",  32'(CPU_RST),   32'd0);

        // DEPTH+1 = 1025 = 0x0401 is rejected after the header
        img = '{8'h04, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load(img, 1'b0, -1);
        check("big_end_edge", 32'(end_edge), 32'd2);
        check("big_err",      32'(ERR),      32'd1);
        check("big_done",     32'(DONE),     32'd0);
        check("big_cpu_rst",  32'(CPU_RST),  32'd1);
        check("big_we_count", 32'(wa.size()), 32'd0);
        repeat (3) @(negedge CLK);
        check("big_err_held", 32'(ERR), 32'd1);

        img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load(img, 1'b0, -1);
        check("after_fail_done", 32'(DONE), 32'd1);
        check("after_fail_err",  32'(ERR),  32'd0);
        check("after_fail_we",   32'(wa.size()), 32'd1);
        if (wa.size() == 1) check("after_fail_data", wd[0], 32'h1122_3344);

        // Valid only on even edges: header at k=2,4, data at k=6..12, WRITE, FIN after edge 13
        img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(img, 1'b1, -1);
        check("tog_end_edge", 32'(end_edge), 32'd13);
        check("tog_consumed", 32'(consumed), 32'd6);
        check("tog_we_count", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("tog_addr", wa[0], 32'h0);
            check("tog_data", wd[0], 32'hDEAD_BEEF);
            check("tog_rdy_in_write", 32'(wr[0]), 32'd0);
        end
        check("tog_done", 32'(DONE), 32'd1);

        // Reset after the second data byte of a two-word image
        img = '{8'h00, 8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        run_load(img, 1'b0, 4);
        check("mid_busy", 32'(BUSY), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge CLK);
        RST = 1'b1;
        img = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(img, 1'b0, -1);
        check("post_rst_we_count", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("post_rst_addr", wa[0], 32'h0);
            check("post_rst_data", wd[0], 32'hAABB_CCDD);
        end
        check("post_rst_done", 32'(DONE), 32'd1);

        // Reload from FIN: CPU_RST rises and DONE clears on the START edge
        img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        run_load(img, 1'b0, -1);
        check("reload_cpu_rst_e0", 32'(cpu_rst_e0), 32'd1);
        check("reload_done_e0",    32'(done_e0),    32'd0);
        check("reload_end_edge",   32'(end_edge),   32'd7);
        check("reload_we_count",   32'(wa.size()),  32'd1);
        if (wa.size() == 1) begin
            check("reload_addr", wa[0], 32'h0);
            check("reload_data", wd[0], 32'h1234_5678);
        end
        check("reload_done",    32'(DONE),    32'd1);
        check("reload_cpu_rst", 32'(CPU_RST), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the instruction-fetch stage. It receives a program image as a byte stream, assembles big-endian 32-bit instructions, and writes them through the fetch stage's instruction-memory write port (`W_Ins`/`WE`). It holds the fetch stage in reset until the image is fully written, so the first fetch after load starts at PC 0 with valid memory.

## Interface
- `DEPTH`, 1024: instruction-memory capacity in words; the maximum accepted word count.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word (word-aligned).
- `CLK` input 1: single system clock, rising edge.
- `RST` input 1: reset, asynchronous, active-low.
- `START` input 1: single-cycle request to begin a load.
- `RX_VALID` input 1: byte available on `RX_DATA`.
- `RX_DATA` input 8: stream byte.
- `RX_READY` output 1: loader accepts a byte this cycle; a transfer occurs when `RX_VALID && RX_READY`.
- `W_ADDR` output 32: byte address of the word being written.
- `W_Ins` output 32: instruction word to write.
- `WE` output 1: one-cycle write strobe to the instruction memory.
- `CPU_RST` output 1: active-high reset to the fetch stage and the rest of the core.
- `BUSY` output 1: a load is in progress.
- `DONE` output 1: the last load completed successfully.
- `ERR` output 1: the last load was rejected.

## Operation
- Stream format: 16-bit word count N (high byte first), then N×4 instruction bytes, MSB first (byte 0 → `W_Ins[31:24]`).
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, FIN, FAIL.
- IDLE: `CPU_RST`=1. `START` → HDR_HI, clear `DONE`/`ERR`, `W_ADDR`←`BASE_ADDR`.
- HDR_HI: on transfer, latch count[15:8] → HDR_LO.
- HDR_LO: on transfer, latch count[7:0], then:
  - N > `DEPTH` → FAIL.
  - N == 0 → FIN.
  - else → DATA with byte index 0.
- DATA: on each transfer, shift the byte into the word register and increment the 2-bit byte index. The 4th byte → WRITE.
- WRITE: `WE`=1 for exactly this cycle, with `W_ADDR`/`W_Ins` stable. Next cycle: `W_ADDR`+=4, remaining−=1. If remaining reaches 0 → FIN, else → DATA.
- FIN: `CPU_RST`=0, `DONE`=1, `BUSY`=0. `START` → HDR_HI with `CPU_RST` reasserted the same edge (reload).
- FAIL: `CPU_RST`=1, `ERR`=1. `START` → HDR_HI.
- `START` is ignored in HDR_HI/HDR_LO/DATA/WRITE.
- `RX_VALID` with `RX_READY` low is ignored; no byte is consumed.
- `W_ADDR` is 32-bit unsigned and wraps modulo 2^32 (unreachable with legal `DEPTH`).

## Timing
- Reset values: state IDLE, `CPU_RST`=1, `WE`=0, `W_ADDR`=`BASE_ADDR`, `W_Ins`=0, `RX_READY`=0, `BUSY`=0, `DONE`=0, `ERR`=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from `RX_VALID` to any output.
- `RX_READY`=1 exactly in HDR_HI, HDR_LO and DATA. It is 0 in WRITE, so the stream stalls one cycle per word.
- `BUSY`=1 in HDR_HI through WRITE.
- Minimum load time is 2 + 5N cycles from the `START` edge to FIN, with `RX_VALID` held high.
- `WE` asserts the cycle after the 4th byte of a word is accepted.
- `CPU_RST` falls on the edge entering FIN, i.e. one cycle after the last `WE`.
- `RST` asserted mid-load: immediate return to reset values. A partial image stays in memory; `CPU_RST` stays high.

## Structure
- Shared package `loader_pkg`: state enumeration, header length (2 bytes), byte-order constant, count width (16).
- One sub-module, `word_packer`: a 4-byte MSB-first shift register with byte index, a `load` strobe, and a `full` flag. The FSM, address and remaining-count counters stay in `imem_loader`.

## Test plan
- N=2, bytes 00 02 | 24 08 00 05 | 00 00 00 0C, `RX_VALID` held high:
  - `WE` pulses twice: (0x0, 0x24080005), then (0x4, 0x0000000C).
  - `DONE`=1 and `CPU_RST`=0 at cycle 12 after `START`.
- N=0 (00 00): FIN after 2 transfers, no `WE` pulse, `DONE`=1.
- N=`DEPTH`+1: FAIL after the header, `ERR`=1, `CPU_RST` stays 1, no `WE`. A following `START` with a valid image → `DONE`=1, `ERR`=0.
- N=1 with `RX_VALID` toggling every other cycle: only handshaked bytes are consumed. A single `WE` with word 0xDEADBEEF at 0x0; `RX_READY` is 0 in the WRITE cycle.
- `RST` low after the 2nd data byte: all outputs return to reset values asynchronously. A subsequent full load writes from `BASE_ADDR` again.
- In FIN, `START` with N=1: `CPU_RST` rises on the same edge and `DONE` clears. The new word is written at `BASE_ADDR`, then FIN is re-entered.
